// File: rtl/sap_control_unit.sv
// Microcode sequencer for the SAP-1.5 computer: steps T0..T4 per instruction and
// decodes (step, opcode, flags) into one-hot datapath controls; latches HALT on HLT.
module sap_control_unit #(
  parameter int                   OPCODE_W   = 4,
  parameter int                   STEP_W     = 3,
  parameter logic [OPCODE_W-1:0]  HLT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_zero,
  input  logic                flag_carry,
  output logic                pc_oe,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                mar_load,
  output logic                ram_oe,
  output logic                ram_we,
  output logic                ir_load,
  output logic                ir_oe,
  output logic                a_load,
  output logic                a_oe,
  output logic                b_load,
  output logic                alu_oe,
  output logic                alu_sub,
  output logic                flags_load,
  output logic                out_load,
  output logic                halt,
  output logic [STEP_W-1:0]   step
);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_LDB = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h9);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);

  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;

  // NOP and the undefined opcodes have no execute phase and finish after fetch.
  function automatic logic is_fetch_only(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA,
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, HLT_OPCODE: is_fetch_only = 1'b0;
      default:                                          is_fetch_only = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = T0;
    halted_d = halted_q;
    if (!halted_q) begin
      case (step_q)
        T0: step_d = T1;
        T1: step_d = is_fetch_only(opcode) ? T0 : T2;
        T2: begin
          case (opcode)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: step_d = T3;
            HLT_OPCODE:                             halted_d = 1'b1;
            default:                                step_d = T0;
          endcase
        end
        T3: step_d = (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
        default: step_d = T0;
      endcase
    end
  end

  always_comb begin
    pc_oe      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_oe     = 1'b0;
    ram_we     = 1'b0;
    ir_load    = 1'b0;
    ir_oe      = 1'b0;
    a_load     = 1'b0;
    a_oe       = 1'b0;
    b_load     = 1'b0;
    alu_oe     = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halt       = reset & halted_q;
    step       = step_q;
    if (reset && !halted_q) begin
      case (step_q)
        T0: begin pc_oe = 1'b1; mar_load = 1'b1; end
        T1: begin ram_oe = 1'b1; ir_load = 1'b1; pc_inc = 1'b1; end
        T2: begin
          case (opcode)
            OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin ir_oe = 1'b1; mar_load = 1'b1; end
            OP_LDI: begin ir_oe = 1'b1; a_load = 1'b1; end
            OP_JMP: begin ir_oe = 1'b1; pc_load = 1'b1; end
            OP_JC:  begin ir_oe = flag_carry; pc_load = flag_carry; end
            OP_JZ:  begin ir_oe = flag_zero;  pc_load = flag_zero;  end
            OP_OUT: begin a_oe = 1'b1; out_load = 1'b1; end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         begin ram_oe = 1'b1; a_load = 1'b1; end
            OP_LDB, OP_ADD,
            OP_SUB:         begin ram_oe = 1'b1; b_load = 1'b1; end
            OP_STA:         begin a_oe = 1'b1; ram_we = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe     = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_control_unit.sv
// Directed bench for sap_control_unit: walks each instruction class cycle by cycle
// and compares the packed control word and step against hand-written tables.
module tb_sap_control_unit;

  localparam logic [15:0] C_PC_OE   = 16'h8000;
  localparam logic [15:0] C_PC_INC  = 16'h4000;
  localparam logic [15:0] C_PC_LD   = 16'h2000;
  localparam logic [15:0] C_MAR     = 16'h1000;
  localparam logic [15:0] C_RAM_OE  = 16'h0800;
  localparam logic [15:0] C_RAM_WE  = 16'h0400;
  localparam logic [15:0] C_IR_LD   = 16'h0200;
  localparam logic [15:0] C_IR_OE   = 16'h0100;
  localparam logic [15:0] C_A_LD    = 16'h0080;
  localparam logic [15:0] C_A_OE    = 16'h0040;
  localparam logic [15:0] C_B_LD    = 16'h0020;
  localparam logic [15:0] C_ALU_OE  = 16'h0010;
  localparam logic [15:0] C_ALU_SUB = 16'h0008;
  localparam logic [15:0] C_FLAGS   = 16'h0004;
  localparam logic [15:0] C_OUT_LD  = 16'h0002;
  localparam logic [15:0] C_HALT    = 16'h0001;

  localparam logic [15:0] F_T0 = C_PC_OE | C_MAR;
  localparam logic [15:0] F_T1 = C_RAM_OE | C_IR_LD | C_PC_INC;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       flag_zero, flag_carry;
  logic pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt;
  logic [2:0] step;
  logic [15:0] ctrl;

  int n_checks = 0;
  int n_errors = 0;

  sap_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .pc_oe(pc_oe), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
    .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe),
    .a_load(a_load), .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
    .halt(halt), .step(step)
  );

  always #5 clk = ~clk;

  assign ctrl = {pc_oe, pc_inc, pc_load, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                 a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Check the current step, then advance one clock and settle.
  task automatic cyc(input string tag, input logic [15:0] ec, input logic [2:0] es);
    check({tag, ".ctrl"}, 32'(ctrl), 32'(ec));
    check({tag, ".step"}, 32'(step), 32'(es));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    opcode = op;
    cyc({tag, ".T0"}, F_T0, 3'd0);
    cyc({tag, ".T1"}, F_T1, 3'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; opcode = 4'h0; flag_zero = 1'b0; flag_carry = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst.ctrl", 32'(ctrl), 32'h0);
      check("rst.step", 32'(step), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b1; #1;

    fetch("lda", 4'h1);
    cyc("lda.T2", C_IR_OE | C_MAR, 3'd2);
    cyc("lda.T3", C_RAM_OE | C_A_LD, 3'd3);

    fetch("ldb", 4'h2);
    cyc("ldb.T2", C_IR_OE | C_MAR, 3'd2);
    cyc("ldb.T3", C_RAM_OE | C_B_LD, 3'd3);

    fetch("add", 4'h3);
    cyc("add.T2", C_IR_OE | C_MAR, 3'd2);
    cyc("add.T3", C_RAM_OE | C_B_LD, 3'd3);
    cyc("add.T4", C_ALU_OE | C_A_LD | C_FLAGS, 3'd4);

    fetch("sub", 4'h4);
    cyc("sub.T2", C_IR_OE | C_MAR, 3'd2);
    cyc("sub.T3", C_RAM_OE | C_B_LD, 3'd3);
    cyc("sub.T4", C_ALU_OE | C_A_LD | C_FLAGS | C_ALU_SUB, 3'd4);

    fetch("sta", 4'h5);
    cyc("sta.T2", C_IR_OE | C_MAR, 3'd2);
    cyc("sta.T3", C_A_OE | C_RAM_WE, 3'd3);

    fetch("ldi", 4'h6);
    cyc("ldi.T2", C_IR_OE | C_A_LD, 3'd2);

    fetch("jmp", 4'h7);
    cyc("jmp.T2", C_IR_OE | C_PC_LD, 3'd2);

    flag_carry = 1'b0; flag_zero = 1'b1;
    fetch("jc0", 4'h8);
    cyc("jc0.T2", 16'h0, 3'd2);
    flag_carry = 1'b1; flag_zero = 1'b0;
    fetch("jc1", 4'h8);
    cyc("jc1.T2", C_IR_OE | C_PC_LD, 3'd2);
    fetch("jz0", 4'h9);
    cyc("jz0.T2", 16'h0, 3'd2);
    flag_carry = 1'b0; flag_zero = 1'b1;
    fetch("jz1", 4'h9);
    cyc("jz1.T2", C_IR_OE | C_PC_LD, 3'd2);

    fetch("out", 4'hE);
    cyc("out.T2", C_A_OE | C_OUT_LD, 3'd2);

    fetch("nop", 4'h0);
    fetch("undB", 4'hB);
    fetch("undD", 4'hD);

    // Asynchronous reset in the middle of T3 of ADD.
    fetch("addr", 4'h3);
    cyc("addr.T2", C_IR_OE | C_MAR, 3'd2);
    check("addr.T3.ctrl", 32'(ctrl), 32'(C_RAM_OE | C_B_LD));
    #2 reset = 1'b0;
    #1;
    check("arst.ctrl", 32'(ctrl), 32'h0);
    check("arst.step", 32'(step), 32'h0);
    @(posedge clk); @(negedge clk); reset = 1'b1; #1;
    fetch("post", 4'hB);

    fetch("hlt", 4'hF);
    cyc("hlt.T2", 16'h0, 3'd2);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i); flag_zero = i[0]; flag_carry = i[1];
      #1;
      check("halt.ctrl", 32'(ctrl), 32'(C_HALT));
      check("halt.step", 32'(step), 32'h0);
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b0; #1;
    check("hrst.ctrl", 32'(ctrl), 32'h0);
    @(negedge clk); reset = 1'b1; #1;
    fetch("after", 4'h1);
    cyc("after.T2", C_IR_OE | C_MAR, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
